// File: rtl/des_tdes_mode_ctrl.sv
// des_tdes_mode_ctrl
//   Message-level sequencer wrapped around the pipelined des_TripleDES core.
//   Accepts a start command (key, IV, mode, direction) and a valid/ready block
//   stream, applies ECB or CBC chaining around the core and returns results on
//   a valid/ready output stream with backpressure. The core cannot stall, so
//   issue is metered by credits: blocks in the core plus blocks in the output
//   FIFO never exceed OFIFO_DEPTH.
//
// Parameters
//   OFIFO_DEPTH  output FIFO / side-queue depth (power of two, >= 2)
//
// Ports
//   clk, n_rst                  clock, synchronous active-low reset
//   start, mode, is_encrypt_in  message command (sampled only in IDLE);
//                               mode 0=ECB 1=CBC, is_encrypt_in 1=encrypt
//   key_in[191:0], iv_in[63:0]  K1|K2|K3 and CBC IV, latched on start
//   in_valid/in_ready, in_data, in_last       input block stream
//   out_valid/out_ready, out_data, out_last   result block stream
//   core_valid_in, core_block, core_sk, core_is_encrypt   to core
//   core_valid_out, core_block_out                        from core
//   busy                        high whenever not IDLE
//
// Configuration
//   TDES_CTRL_BLKCNT_EN  adds output blk_cnt[31:0]: cleared on start,
//                        incremented per output handshake, saturating.

module des_tdes_mode_ctrl #(
  parameter int unsigned OFIFO_DEPTH = 8
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic         mode,
  input  logic         is_encrypt_in,
  input  logic [191:0] key_in,
  input  logic [63:0]  iv_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_data,
  output logic         out_last,
  output logic         core_valid_in,
  output logic [63:0]  core_block,
  output logic [191:0] core_sk,
  output logic         core_is_encrypt,
  input  logic         core_valid_out,
  input  logic [63:0]  core_block_out,
  output logic         busy
`ifdef TDES_CTRL_BLKCNT_EN
  ,
  output logic [31:0]  blk_cnt
`endif
);

  localparam int unsigned AW = (OFIFO_DEPTH > 1) ? $clog2(OFIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] OCC_MAX = (CW + 1)'(OFIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]    state;
  logic          mode_r;
  logic          enc_r;
  logic [63:0]   chain;
  logic [CW-1:0] inflight;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occ;

  // Side queue: one entry per block inside the core, in issue order.
  logic [AW-1:0] sq_wp;
  logic [AW-1:0] sq_rp;
  logic [63:0]   sq_mask [OFIFO_DEPTH];
  logic          sq_last [OFIFO_DEPTH];

  // Output FIFO.
  logic [AW-1:0] f_wp;
  logic [AW-1:0] f_rp;
  logic [63:0]   f_data [OFIFO_DEPTH];
  logic          f_last [OFIFO_DEPTH];

  logic issue;
  logic ret;
  logic pop;
  logic cbc_enc;
  logic cbc_dec;

  always_comb begin
    cbc_enc   = mode_r & enc_r;
    cbc_dec   = mode_r & ~enc_r;
    occ       = {1'b0, inflight} + {1'b0, fifo_count};
    // CBC encrypt needs the previous ciphertext before the next issue,
    // so it waits for the core to be empty.
    in_ready  = (state == RUN) && (occ < OCC_MAX) &&
                !(cbc_enc && (inflight != '0));
    issue     = in_valid & in_ready;
    // A core result with nothing outstanding cannot belong to this message.
    ret       = core_valid_out & (inflight != '0);
    out_valid = (fifo_count != '0);
    pop       = out_valid & out_ready;
    out_data  = out_valid ? f_data[f_rp] : '0;
    out_last  = out_valid & f_last[f_rp];
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state           <= IDLE;
      mode_r          <= 1'b0;
      enc_r           <= 1'b0;
      chain           <= '0;
      core_sk         <= '0;
      core_is_encrypt <= 1'b0;
      core_valid_in   <= 1'b0;
      core_block      <= '0;
      inflight        <= '0;
      fifo_count      <= '0;
      sq_wp           <= '0;
      sq_rp           <= '0;
      f_wp            <= '0;
      f_rp            <= '0;
    end else begin
      core_valid_in <= issue;
      // Issue, return and pop may all land in one cycle; each counter nets
      // its own increment and decrement so no credit is lost.
      inflight      <= inflight + CW'(issue) - CW'(ret);
      fifo_count    <= fifo_count + CW'(ret) - CW'(pop);

      case (state)
        IDLE: begin
          if (start) begin
            state           <= RUN;
            mode_r          <= mode;
            enc_r           <= is_encrypt_in;
            core_sk         <= key_in;
            core_is_encrypt <= is_encrypt_in;
            chain           <= iv_in;
          end
        end
        RUN: begin
          if (issue && in_last) state <= DRAIN;
        end
        DRAIN: begin
          if ((inflight == '0) && (fifo_count == '0)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (issue) begin
        core_block <= cbc_enc ? (in_data ^ chain) : in_data;
        sq_wp      <= sq_wp + AW'(1);
        if (cbc_dec) chain <= in_data;
      end

      if (ret) begin
        sq_rp <= sq_rp + AW'(1);
        f_wp  <= f_wp + AW'(1);
        if (cbc_enc) chain <= core_block_out;
      end

      if (pop) f_rp <= f_rp + AW'(1);
    end
  end

  // Storage arrays need no reset: pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    if (n_rst && issue) begin
      sq_mask[sq_wp] <= cbc_dec ? chain : '0;
      sq_last[sq_wp] <= in_last;
    end
    if (n_rst && ret) begin
      f_data[f_wp] <= core_block_out ^ sq_mask[sq_rp];
      f_last[f_wp] <= sq_last[sq_rp];
    end
  end

`ifdef TDES_CTRL_BLKCNT_EN
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      blk_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      blk_cnt <= '0;
    end else if (pop && (blk_cnt != '1)) begin
      blk_cnt <= blk_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_des_tdes_mode_ctrl.sv
// tb_des_tdes_mode_ctrl
//   Randomized scoreboard bench for des_tdes_mode_ctrl. A stand-in pipelined
//   block cipher (fixed latency, invertible, key dependent) plays the core.
//   The driver computes ECB/CBC results from the chaining rules and queues
//   them; a monitor pops and compares on every output handshake.

module tb_des_tdes_mode_ctrl;

  localparam int DEPTH = 8;
  localparam int CL    = 4;
  localparam logic [191:0] KEY0 = {3{64'h133457799BBCDFF1}};

  logic         clk;
  logic         n_rst;
  logic         start;
  logic         mode;
  logic         is_encrypt_in;
  logic [191:0] key_in;
  logic [63:0]  iv_in;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic         out_last;
  logic         core_valid_in;
  logic [63:0]  core_block;
  logic [191:0] core_sk;
  logic         core_is_encrypt;
  logic         core_valid_out;
  logic [63:0]  core_block_out;
  logic         busy;
`ifdef TDES_CTRL_BLKCNT_EN
  logic [31:0]  blk_cnt;
`endif

  des_tdes_mode_ctrl #(.OFIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .start          (start),
    .mode           (mode),
    .is_encrypt_in  (is_encrypt_in),
    .key_in         (key_in),
    .iv_in          (iv_in),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_last        (in_last),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .core_valid_in  (core_valid_in),
    .core_block     (core_block),
    .core_sk        (core_sk),
    .core_is_encrypt(core_is_encrypt),
    .core_valid_out (core_valid_out),
    .core_block_out (core_block_out),
    .busy           (busy)
`ifdef TDES_CTRL_BLKCNT_EN
    ,
    .blk_cnt        (blk_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int accepted = 0;
  int ov_seen = 0;
  int ready_mode = 1;   // 0: hold low, 1: hold high, 2: random
  int st;
  int st_full;
  bit full_done;

  logic         cur_mode;
  logic         cur_enc;
  logic [191:0] cur_key;
  logic [63:0]  model_chain;
  logic [64:0]  exp_q [$];
  logic [63:0]  src [$];
  logic [63:0]  ct_log [$];

  // Stand-in cipher: invertible per key, distinct in each direction.
  function automatic logic [63:0] core_f(input logic [63:0] b, input logic [191:0] k,
                                         input logic enc);
    logic [63:0] t;
    if (enc) begin
      t = b ^ k[191:128];
      t = {t[56:0], t[63:57]};
      t = t + k[127:64];
      t = t ^ k[63:0];
    end else begin
      t = b ^ k[63:0];
      t = t - k[127:64];
      t = {t[6:0], t[63:7]};
      t = t ^ k[191:128];
    end
    return t;
  endfunction

  // Core stand-in: CL-stage pipeline, shares n_rst, never stalls.
  logic [CL-1:0] cv;
  logic [63:0]   cd [CL];
  always @(posedge clk) begin
    if (!n_rst) cv <= '0;
    else        cv <= {cv[CL-2:0], core_valid_in};
    cd[0] <= core_f(core_block, core_sk, core_is_encrypt);
    for (int i = 1; i < CL; i++) cd[i] <= cd[i-1];
  end
  assign core_valid_out = cv[CL-1];
  assign core_block_out = cd[CL-1];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_out"},  {out_valid, out_last, out_data}, '0);
    chk({tag, "_core"}, {core_valid_in, core_is_encrypt, core_block}, '0);
    chk({tag, "_sk"},   core_sk, '0);
    chk({tag, "_ctl"},  {in_ready, busy}, '0);
  endtask

  // out_ready driver
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on each handshake; also checks that a
  // stalled output holds its data.
  initial begin
    logic [64:0] e;
    logic [64:0] held;
    bit hold_pend;
    hold_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        hold_pend = 1'b0;
      end else begin
        if (out_valid) ov_seen++;
        if (hold_pend && out_valid) chk("out_hold_stable", {out_last, out_data}, held);
        hold_pend = 1'b0;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_unexpected: got %0h, want no output", {out_last, out_data});
          end else begin
            e = exp_q.pop_front();
            chk("out_block", {out_last, out_data}, e);
          end
        end else if (out_valid) begin
          held = {out_last, out_data};
          hold_pend = 1'b1;
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    @(negedge clk);
    while (busy && c < 1000) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s: busy=%0d after %0d cycles, want 0", name, busy, c);
    end
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 with the DUT idle.
  task automatic do_start(input logic m, input logic enc, input logic [191:0] k,
                          input logic [63:0] iv, input bit with_valid);
    start = 1'b1; mode = m; is_encrypt_in = enc; key_in = k; iv_in = iv;
    if (with_valid) begin
      in_valid = 1'b1; in_data = {$urandom, $urandom}; in_last = 1'b1;
    end
    @(negedge clk);
    if (with_valid) chk("in_ready_in_idle", in_ready, '0);
    @(posedge clk);
    #1;
    start = 1'b0; in_valid = 1'b0;
    // Command inputs wander mid-message; the DUT must ignore them.
    key_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    mode = ~m; is_encrypt_in = ~enc;
    cur_mode = m; cur_enc = enc; cur_key = k; model_chain = iv;
  endtask

  task automatic send_blocks(input int n, input int gap_pct, input bit use_src,
                             input bit pulse_start, input bit nolast, output int stalls);
    logic [63:0] d;
    logic [63:0] r;
    int waitc;
    bit ok;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        @(posedge clk);
        #1;
      end
      d = (use_src && i < src.size()) ? src[i] : {$urandom, $urandom};
      in_data = d; in_last = (i == n - 1) && !nolast; in_valid = 1'b1;
      if (pulse_start && i == 1) begin
        start = 1'b1; key_in = ~cur_key; mode = ~cur_mode; iv_in = ~iv_in;
      end
      ok = 1'b0; waitc = 0;
      while (!ok && waitc < 300) begin
        @(negedge clk);
        if (in_ready) ok = 1'b1;
        else begin stalls++; waitc++; end
      end
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout: in_ready=0 for %0d cycles, want 1", waitc);
      end else begin
        if (!cur_mode) begin
          r = core_f(d, cur_key, cur_enc);
        end else if (cur_enc) begin
          r = core_f(d ^ model_chain, cur_key, 1'b1);
          model_chain = r;
        end else begin
          r = core_f(d, cur_key, 1'b0) ^ model_chain;
          model_chain = d;
        end
        exp_q.push_back({in_last, r});
        ct_log.push_back(r);
        accepted++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0; start = 1'b0;
      if (ok && cur_mode && cur_enc && i != n - 1) begin
        @(negedge clk);
        chk("cbcenc_in_ready_hold", in_ready, '0);
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    int c;
    n_rst = 1'b0; start = 1'b0; mode = 1'b0; is_encrypt_in = 1'b0;
    key_in = '0; iv_in = '0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    cur_mode = 1'b0; cur_enc = 1'b0; cur_key = '0; model_chain = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk);
    #1;
    n_rst = 1'b1;

    // ECB encrypt single block; start issued together with in_valid.
    ready_mode = 1;
    do_start(1'b0, 1'b1, KEY0, '0, 1'b1);
    src.delete(); src.push_back(64'h0123456789ABCDEF);
    send_blocks(1, 0, 1'b1, 1'b0, 1'b0, st);
    wait_idle("ecb1_idle");
`ifdef TDES_CTRL_BLKCNT_EN
    chk("blk_cnt", blk_cnt, 1);
`endif

    // CBC encrypt three blocks, then decrypt the ciphertext back.
    src.delete(); ct_log.delete();
    src.push_back(64'h0123456789ABCDEF);
    src.push_back({$urandom, $urandom});
    src.push_back({$urandom, $urandom});
    do_start(1'b1, 1'b1, KEY0, '0, 1'b0);
    send_blocks(3, 0, 1'b1, 1'b0, 1'b0, st);
    wait_idle("cbcenc_idle");
    src = ct_log;
    ct_log.delete();
    do_start(1'b1, 1'b0, KEY0, '0, 1'b0);
    send_blocks(3, 0, 1'b1, 1'b0, 1'b0, st);
    chk("cbcdec_stalls", st, 0);
    wait_idle("cbcdec_idle");

    // Backpressure: exactly DEPTH blocks accepted while the output is blocked.
    ready_mode = 0; accepted = 0; full_done = 1'b0;
    do_start(1'b0, 1'b1, KEY0, '0, 1'b0);
    fork
      begin
        send_blocks(20, 0, 1'b0, 1'b0, 1'b0, st_full);
        full_done = 1'b1;
      end
    join_none
    repeat (60) @(posedge clk);
    @(negedge clk);
    chk("full_accepted", accepted, DEPTH);
    chk("full_in_ready", in_ready, '0);
    @(posedge clk);
    #1;
    ready_mode = 1;
    c = 0;
    while (!full_done && c < 2000) begin
      @(posedge clk);
      c++;
    end
    #1;
    checks++;
    if (!full_done) begin
      errors++;
      $display("FAIL full_release: sender done=%0d after %0d cycles, want 1", full_done, c);
    end
    wait_idle("full_idle");

    // Random messages: modes, lengths, input gaps, output stalls, start pulses.
    for (int m = 0; m < 10; m++) begin
      ready_mode = int'($urandom_range(2, 1));
      do_start(1'($urandom_range(1)), 1'($urandom_range(1)),
               {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom}, 1'b0);
      send_blocks(int'($urandom_range(12, 1)), int'($urandom_range(40)), 1'b0,
                  (m % 3) == 0, 1'b0, st);
      wait_idle("rand_idle");
    end

    // Reset with five blocks outstanding.
    ready_mode = 0;
    do_start(1'b0, 1'b1, KEY0, '0, 1'b0);
    send_blocks(5, 0, 1'b0, 1'b0, 1'b1, st);
    n_rst = 1'b0;
    @(negedge clk);
    exp_q.delete();
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    ready_mode = 1;
    ov_seen = 0;
    @(negedge clk);
    chk_outputs_zero("midrst");
    repeat (20) @(negedge clk);
    chk("midrst_no_out_valid", ov_seen, 0);
    chk("midrst_busy", busy, '0);

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
